// File: rtl/conv_bit_serializer_if.sv
// Word-in / bit-out handshake bundle for conv_bit_serializer.
// The serializer uses the slave view: it consumes words and produces bits.
// The word source and bit sink (the upstream encoder / downstream line side)
// use the master view.
interface conv_bit_serializer_if #(
   parameter int WORD_W = 16
);
   logic [WORD_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic              in_last;
   logic [WORD_W-1:0] punct_mask;
   logic              out_bit;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;

   modport slave (
      input  in_data, in_valid, in_last, punct_mask, out_ready,
      output in_ready, out_bit, out_valid, out_last
   );

   modport master (
      output in_data, in_valid, in_last, punct_mask, out_ready,
      input  in_ready, out_bit, out_valid, out_last
   );
endinterface

// File: rtl/conv_bit_serializer.sv
// conv_bit_serializer: turns 16-bit convolutional-encoder words into an
// MSB-first serial bitstream, one bit per output handshake.
// Optional feature macro: PUNCT_EN. When defined, punct_mask selects which
// bits of each word are transmitted (1 = keep). When undefined every bit is
// sent and last_drop is tied low.
// The kept-bit mask rem_r is priority-encoded from the top, so dropped bits
// cost no cycles. in_ready looks ahead at the final bit handshake so the next
// word loads with no idle cycle between words.
module conv_bit_serializer #(
   parameter int WORD_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   conv_bit_serializer_if.slave bus,
   output logic [CNT_W-1:0] frame_words,
   output logic             last_drop
);

   localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t            state;
   state_t            state_next;
   logic [WORD_W-1:0] data_r;
   logic [WORD_W-1:0] rem_r;
   logic              last_r;
   logic [WORD_W-1:0] kept;
   logic [IDX_W-1:0]  idx;
   logic              one_hot;
   logic              out_hs;
   logic              accept;

`ifdef PUNCT_EN
   assign kept = bus.punct_mask;
`else
   // Without puncturing the mask input has no role; fold it into a sink.
   logic unused_mask;
   assign unused_mask = ^bus.punct_mask;
   assign kept        = '1;
`endif

   // Find the highest still-pending bit; later (higher) indices win.
   always_comb begin
      idx = '0;
      for (int i = 0; i < WORD_W; i++) begin
         if (rem_r[i]) idx = IDX_W'(i);
      end
   end

   assign one_hot = (rem_r != '0) && ((rem_r & (rem_r - WORD_W'(1))) == '0);

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   // Next state and handshake outputs; in_ready never looks at in_valid.
   always_comb begin
      state_next    = state;
      bus.out_valid = (state == SHIFT);
      bus.out_bit   = 1'b0;
      bus.out_last  = 1'b0;
      if (state == SHIFT) begin
         bus.out_bit  = data_r[idx];
         bus.out_last = last_r && one_hot;
      end
      out_hs       = bus.out_valid && bus.out_ready;
      bus.in_ready = (state == IDLE) || (out_hs && one_hot);
      accept       = bus.in_valid && bus.in_ready;
      if (accept) begin
         state_next = (kept != '0) ? SHIFT : IDLE;
      end else if (out_hs && one_hot) begin
         state_next = IDLE;
      end
   end

   // Word capture on acceptance; retire one kept bit per output handshake.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_r <= '0;
         rem_r  <= '0;
         last_r <= 1'b0;
      end else if (accept) begin
         data_r <= bus.in_data;
         rem_r  <= kept;
         last_r <= bus.in_last;
      end else if (out_hs) begin
         rem_r[idx] <= 1'b0;
      end
   end

   // Per-frame word count: saturating, cleared by the frame's last word.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_words <= '0;
      end else if (accept) begin
         if (bus.in_last)              frame_words <= '0;
         else if (frame_words != '1)   frame_words <= frame_words + CNT_W'(1);
      end
   end

`ifdef PUNCT_EN
   // Sticky flag: a frame's last word was punctured away entirely.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                     last_drop <= 1'b0;
      else if (accept && bus.in_last && kept == '0)     last_drop <= 1'b1;
   end
`else
   assign last_drop = 1'b0;
`endif

endmodule

// File: tb/tb_conv_bit_serializer.sv
// Self-checking bench for conv_bit_serializer. A queue of pending bits
// (value, last-flag) is the reference: each accepted word appends its kept
// bits MSB first, each output handshake removes the head. Output valid,
// data, last and input ready are all predicted from that queue.
module tb_conv_bit_serializer;

   typedef struct {
      logic b;
      logic l;
   } ent_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] frame_words;
   logic        last_drop;

   conv_bit_serializer_if #(.WORD_W(16)) bus ();

   conv_bit_serializer #(.WORD_W(16), .CNT_W(16)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .bus         (bus),
      .frame_words (frame_words),
      .last_drop   (last_drop)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   ent_t        q[$];
   int          fc = 0;
   logic        ld = 1'b0;
   logic [63:0] cap = '0;
   int          ncap = 0;
   int          rdy_mode = 0;
   int          pidx = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic next_ready();
      logic [3:0] pat;
      pat = 4'b1001;
      case (rdy_mode)
         1:       return ($urandom_range(0, 3) != 0);
         2:       return pat[3 - (pidx % 4)];
         default: return 1'b1;
      endcase
   endfunction

   task automatic model_accept(input logic [15:0] d, input logic il, input logic [15:0] m);
      logic [15:0] kept;
      int          low;
`ifdef PUNCT_EN
      kept = m;
`else
      kept = m | 16'hFFFF;
`endif
      low = -1;
      for (int k = 0; k < 16; k++) if (kept[k] && low < 0) low = k;
      for (int k = 15; k >= 0; k--) if (kept[k]) q.push_back('{d[k], il && (k == low)});
      if (il) begin
         fc = 0;
         if (kept == 16'h0) ld = 1'b1;
      end else if (fc < 65535) begin
         fc++;
      end
   endtask

   // One clock cycle: drive at the falling edge, check 1 ns later, then
   // advance the model by what the coming rising edge will do.
   task automatic cyc(input logic iv, input logic [15:0] d, input logic il,
                      input logic [15:0] m, output logic acc);
      logic mrdy;
      @(negedge clk);
      bus.in_valid   = iv;
      bus.in_data    = d;
      bus.in_last    = il;
      bus.punct_mask = m;
      bus.out_ready  = next_ready();
      pidx++;
      #1;
      check("out_valid", bus.out_valid, q.size() != 0);
      if (q.size() != 0) begin
         check("out_bit", bus.out_bit, q[0].b);
         check("out_last", bus.out_last, q[0].l);
      end
      mrdy = (q.size() == 0) || (bus.out_ready && q.size() == 1);
      check("in_ready", bus.in_ready, mrdy);
      check("frame_words", frame_words, fc);
      check("last_drop", last_drop, ld);
      acc = iv && mrdy;
      if (q.size() != 0 && bus.out_ready) begin
         cap = {cap[62:0], q[0].b};
         ncap++;
         void'(q.pop_front());
      end
      if (acc) model_accept(d, il, m);
   endtask

   task automatic send_word(input logic [15:0] d, input logic il, input logic [15:0] m);
      logic acc;
      int   n;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 400) begin
         cyc(1'b1, d, il, m, acc);
         n++;
      end
      if (!acc) check("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) cyc(1'b0, 16'($urandom), 1'b0, 16'($urandom), acc);
   endtask

   task automatic drain();
      logic acc;
      int   n;
      n = 0;
      while (q.size() != 0 && n < 400) begin
         cyc(1'b0, 16'h0, 1'b0, 16'h0, acc);
         n++;
      end
      check("drain_timeout", q.size(), 0);
      cyc(1'b0, 16'h0, 1'b0, 16'h0, acc);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_out_bit", bus.out_bit, 1'b0);
      check("rst_out_last", bus.out_last, 1'b0);
      check("rst_in_ready", bus.in_ready, 1'b1);
      check("rst_frame_words", frame_words, 0);
      check("rst_last_drop", last_drop, 1'b0);
      q.delete();
      fc = 0;
      ld = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.in_last    = 1'b0;
      bus.punct_mask = '0;
      bus.out_ready  = 1'b1;
      do_reset();

      // MSB-first order and latency with an always-ready sink.
      rdy_mode = 0;
      cap = '0; ncap = 0;
      send_word(16'hA5C3, 1'b0, 16'hFFFF);
      drain();
      check("a5c3_seq", cap[15:0], 16'hA5C3);
      check("a5c3_cnt", ncap, 16);

      // Back-to-back words: no gap between them.
      cap = '0; ncap = 0;
      send_word(16'hFFFF, 1'b0, 16'hFFFF);
      send_word(16'h0000, 1'b0, 16'hFFFF);
      drain();
      check("b2b_seq", cap[31:0], 32'hFFFF0000);
      check("b2b_cnt", ncap, 32);

      // Three-word frame; the last word clears the counter.
      send_word(16'h1234, 1'b0, 16'hFFFF);
      send_word(16'h5678, 1'b0, 16'hFFFF);
      send_word(16'h9ABC, 1'b1, 16'hFFFF);
      drain();
      check("frame_clear", frame_words, 0);

      // Puncturing: 16'hEEEE keeps 12 of 16 bits.
      cap = '0; ncap = 0;
      send_word(16'hFFFF, 1'b0, 16'hEEEE);
      drain();
`ifdef PUNCT_EN
      check("punct_cnt", ncap, 12);
      send_word(16'hBEEF, 1'b1, 16'h0000);
      idle(2);
      check("last_drop_set", last_drop, 1'b1);
`else
      check("nopunct_cnt", ncap, 16);
`endif

      // Reset in the middle of a word after five bits have gone out.
      cap = '0; ncap = 0;
      send_word(16'hA5C3, 1'b0, 16'hFFFF);
      idle(5);
      check("pre_rst_cnt", ncap, 5);
      check("pre_rst_bits", cap[4:0], 5'b10100);
      do_reset();

      // Stalling sink (ready 1,0,0,1,...) on 16'h8001: nothing lost or repeated.
      rdy_mode = 2; pidx = 0;
      cap = '0; ncap = 0;
      send_word(16'h8001, 1'b0, 16'hFFFF);
      drain();
      check("stall_seq", cap[15:0], 16'h8001);
      check("stall_cnt", ncap, 16);

      // Randomized traffic with a randomly stalling sink.
      rdy_mode = 1;
      for (int w = 0; w < 150; w++) begin
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         send_word(16'($urandom), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom));
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
